// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared constants, state encoding and cell index helper for the tile renderer
//
// Purpose: map geometry (20x15 cells of 32x32 pixels), pixel width, fill tile,
//          FSM state encoding and the row-major cell index function.
// Ports:   none (package).
package tile_pkg;

   localparam int MAP_W      = 20;
   localparam int MAP_H      = 15;
   localparam int MAP_CELLS  = 300;
   localparam int TILE_LOG2  = 5;
   localparam int PIX_W      = 12;
   localparam int CELL_AW    = 9;

   localparam logic [3:0] RESET_TILE = 4'd1;

   typedef enum logic {
      FILL = 1'b0,
      IDLE = 1'b1
   } state_t;

   // y*20 + x built from shifts so no multiplier is inferred.
   function automatic logic [CELL_AW-1:0] cell_idx(input logic [4:0] x, input logic [3:0] y);
      logic [CELL_AW-1:0] yw;
      yw = {5'd0, y};
      return (yw << 4) + (yw << 2) + {4'd0, x};
   endfunction

endpackage

// File: rtl/tile_renderer_if.sv
// rtl/tile_renderer_if.sv - tile write / refill control bus between game logic and the renderer
//
// Purpose: groups the single-tile write port and the refill control.
// Signals: wr_en/wr_x/wr_y/wr_tile  tile write request (master -> slave)
//          clr                      start a refill of the whole map (master -> slave)
//          wr_ready                 write accepted this cycle (slave -> master)
//          busy                     refill in progress (slave -> master)
interface tile_renderer_if;

   logic       wr_en;
   logic [4:0] wr_x;
   logic [3:0] wr_y;
   logic [3:0] wr_tile;
   logic       wr_ready;
   logic       clr;
   logic       busy;

   modport master (
      output wr_en, wr_x, wr_y, wr_tile, clr,
      input  wr_ready, busy
   );

   modport slave (
      input  wr_en, wr_x, wr_y, wr_tile, clr,
      output wr_ready, busy
   );

endinterface

// File: rtl/tile_map_ram.sv
// rtl/tile_map_ram.sv - 300 x 4-bit tile map storage
//
// Purpose: register array holding one tile index per map cell.
// Ports:   clk      pixel clock
//          we_i     write enable (synchronous write)
//          waddr_i  write cell index
//          wdata_i  write tile index
//          raddr_i  read cell index (combinational read)
//          rdata_o  tile index at raddr_i
module tile_map_ram
   import tile_pkg::*;
(
   input  logic               clk,
   input  logic               we_i,
   input  logic [CELL_AW-1:0] waddr_i,
   input  logic [3:0]         wdata_i,
   input  logic [CELL_AW-1:0] raddr_i,
   output logic [3:0]         rdata_o
);

   // No reset on purpose: contents are only ever initialised by the fill sequence.
   logic [3:0] mem_q [MAP_CELLS];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tile_renderer.sv
// rtl/tile_renderer.sv - tile map lookup, tile-ROM addressing and pixel/sync output stage
//
// Purpose: maps h_cnt/v_cnt to a tile-ROM address through the 20x15 tile map,
//          registers the returned colour as the pixel, and delays the syncs to
//          stay aligned. A fill FSM writes RESET_TILE to every cell after reset
//          or on clr; otherwise single tiles are written through wr_if.
// Ports:   clk, rst             pixel clock, synchronous active-high reset
//          h_cnt, v_cnt, valid  timing generator position and active-area flag
//          hsync_in, vsync_in   active-low syncs in
//          wr_if                tile write / refill bus (slave side)
//          rom_addr, rom_data   tile-ROM address out, colour in (1-cycle ROM)
//          pixel                {R,G,B} out
//          hsync_out, vsync_out syncs delayed by 3 cycles
module tile_renderer
   import tile_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [9:0]       h_cnt,
   input  logic [9:0]       v_cnt,
   input  logic             valid,
   input  logic             hsync_in,
   input  logic             vsync_in,
   tile_renderer_if.slave   wr_if,
   output logic [13:0]      rom_addr,
   input  logic [PIX_W-1:0] rom_data,
   output logic [PIX_W-1:0] pixel,
   output logic             hsync_out,
   output logic             vsync_out
);

   state_t             state_q, state_d;
   logic [CELL_AW-1:0] fill_cnt_q, fill_cnt_d;

   logic               ram_we;
   logic [CELL_AW-1:0] ram_waddr;
   logic [3:0]         ram_wdata;
   logic               busy_c, wr_ready_c;

   logic [4:0]         rd_col;
   logic [3:0]         rd_row;
   logic               rd_in_range;
   logic [CELL_AW-1:0] rd_addr;
   logic [3:0]         rd_tile;
   logic [3:0]         map_tile;

   logic               wr_in_range;

   logic [13:0]        rom_addr_q, rom_addr_d;
   logic [PIX_W-1:0]   pixel_q, pixel_d;
   logic [1:0]         valid_q;
   logic [2:0]         hs_q, vs_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FILL;
         fill_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      case (state_q)
         FILL: begin
            // clr is ignored here so a running fill never restarts.
            if (fill_cnt_q == CELL_AW'(MAP_CELLS - 1)) begin
               state_d    = IDLE;
               fill_cnt_d = '0;
            end else begin
               fill_cnt_d = fill_cnt_q + 1'b1;
            end
         end
         IDLE: begin
            if (wr_if.clr) begin
               state_d    = FILL;
               fill_cnt_d = '0;
            end
         end
      endcase
   end

   // ---------------- FSM: outputs and write-source mux ----------------
   assign wr_in_range = (wr_if.wr_x < 5'(MAP_W)) && (wr_if.wr_y < 4'(MAP_H));

   always_comb begin
      busy_c     = 1'b0;
      wr_ready_c = 1'b0;
      ram_we     = 1'b0;
      ram_waddr  = fill_cnt_q;
      ram_wdata  = RESET_TILE;
      case (state_q)
         FILL: begin
            busy_c = 1'b1;
            ram_we = !rst;
         end
         IDLE: begin
            wr_ready_c = 1'b1;
            // clr takes priority: a write issued alongside it is dropped.
            ram_we     = wr_if.wr_en && !wr_if.clr && wr_in_range && !rst;
            ram_waddr  = cell_idx(wr_if.wr_x, wr_if.wr_y);
            ram_wdata  = wr_if.wr_tile;
         end
      endcase
   end

   assign wr_if.busy     = busy_c;
   assign wr_if.wr_ready = wr_ready_c;

   // ---------------- map read ----------------
   assign rd_col      = h_cnt[9:TILE_LOG2];
   assign rd_row      = v_cnt[8:TILE_LOG2];
   assign rd_in_range = (rd_col < 5'(MAP_W)) && !v_cnt[9] && (rd_row < 4'(MAP_H));
   // Keep the RAM index inside the array even when the position is off-map.
   assign rd_addr     = rd_in_range ? cell_idx(rd_col, rd_row) : '0;
   assign map_tile    = rd_in_range ? rd_tile : 4'd0;

   tile_map_ram u_map (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (rd_addr),
      .rdata_o (rd_tile)
   );

   // ---------------- address / pixel pipeline ----------------
   assign rom_addr_d = {map_tile, v_cnt[TILE_LOG2-1:0], h_cnt[TILE_LOG2-1:0]};
   // valid_q[1] lines up with the ROM word currently on rom_data.
   assign pixel_d    = valid_q[1] ? rom_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rom_addr_q <= '0;
         pixel_q    <= '0;
         valid_q    <= '0;
         hs_q       <= '1;
         vs_q       <= '1;
      end else begin
         rom_addr_q <= rom_addr_d;
         pixel_q    <= pixel_d;
         valid_q    <= {valid_q[0], valid};
         hs_q       <= {hs_q[1:0], hsync_in};
         vs_q       <= {vs_q[1:0], vsync_in};
      end
   end

   assign rom_addr  = rom_addr_q;
   assign pixel     = pixel_q;
   assign hsync_out = hs_q[2];
   assign vsync_out = vs_q[2];

endmodule

// File: tb/tb_tile_renderer.sv
// tb/tb_tile_renderer.sv - scoreboard bench for tile_renderer with a tile-grid reference model
module tb_tile_renderer;
   import tile_pkg::*;

   logic        clk = 1'b0;
   always #20 clk = ~clk;

   logic        rst;
   logic [9:0]  h_cnt, v_cnt;
   logic        valid, hsync_in, vsync_in;
   logic [13:0] rom_addr;
   logic [11:0] rom_data;
   logic [11:0] pixel;
   logic        hsync_out, vsync_out;

   tile_renderer_if wr_if ();

   tile_renderer dut (
      .clk       (clk),
      .rst       (rst),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .valid     (valid),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .wr_if     (wr_if),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .pixel     (pixel),
      .hsync_out (hsync_out),
      .vsync_out (vsync_out)
   );

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   logic [3:0] model [20][15];
   bit         model_idle = 1'b0;
   bit         rom_force = 1'b0;

   typedef struct {int due; logic [13:0] addr;} aexp_t;
   typedef struct {int due; logic [11:0] pix; logic hs; logic vs;} pexp_t;
   aexp_t aq[$];
   pexp_t pq[$];

   function automatic logic [11:0] rom_fn(input logic [13:0] a);
      logic [31:0] t;
      t = {18'd0, a} * 32'd2731 + {25'd0, a[13:7]};
      return t[11:0];
   endfunction

   // Synchronous tile ROM model.
   always @(posedge clk) rom_data <= rom_force ? 12'hFFF : rom_fn(rom_addr);

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Tile under a pixel position on the 20x15 grid of 32-pixel tiles; 0 off-map.
   function automatic logic [3:0] tile_at(input int h, input int v);
      if (h / 32 < 20 && v / 32 < 15) return model[h / 32][v / 32];
      return 4'd0;
   endfunction

   task automatic model_fill();
      for (int x = 0; x < 20; x++)
         for (int y = 0; y < 15; y++)
            model[x][y] = 4'd1;
   endtask

   // Monitor: compare whatever is due at this edge.
   initial begin
      aexp_t a;
      pexp_t p;
      forever begin
         @(posedge clk);
         #1;
         while (aq.size() > 0 && aq[0].due == edge_n) begin
            a = aq.pop_front();
            chk("rom_addr", {18'd0, rom_addr}, {18'd0, a.addr});
         end
         while (pq.size() > 0 && pq[0].due == edge_n) begin
            p = pq.pop_front();
            chk("pixel", {20'd0, pixel}, {20'd0, p.pix});
            chk("hsync_out", {31'd0, hsync_out}, {31'd0, p.hs});
            chk("vsync_out", {31'd0, vsync_out}, {31'd0, p.vs});
         end
      end
   end

   task automatic tick(input int h, input int v, input bit vl, input bit hs, input bit vs, input bit track);
      aexp_t a;
      pexp_t p;
      logic [13:0] ea;
      @(negedge clk);
      wr_if.wr_en = 1'b0;
      wr_if.clr   = 1'b0;
      h_cnt    = 10'(h);
      v_cnt    = 10'(v);
      valid    = vl;
      hsync_in = hs;
      vsync_in = vs;
      if (track) begin
         ea = 14'(int'(tile_at(h, v)) * 1024 + (v % 32) * 32 + (h % 32));
         a.due = edge_n + 1; a.addr = ea;
         aq.push_back(a);
         p.due = edge_n + 3; p.pix = vl ? rom_fn(ea) : 12'h000; p.hs = hs; p.vs = vs;
         pq.push_back(p);
      end
   endtask

   task automatic rtick(input bit track);
      int h, v;
      h = $urandom_range(0, 1023);
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(480, 1023) : $urandom_range(0, 479);
      tick(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), track);
   endtask

   task automatic do_wr(input int x, input int y, input int t);
      rtick(1'b1);
      wr_if.wr_en   = 1'b1;
      wr_if.wr_x    = 5'(x);
      wr_if.wr_y    = 4'(y);
      wr_if.wr_tile = 4'(t);
      if (model_idle && x < 20 && y < 15) model[x][y] = 4'(t);
   endtask

   // Count cycles with busy high, starting at the current cycle.
   task automatic wait_fill(input string name, input int wr_at);
      int n;
      n = 0;
      while (n < 1000) begin
         #1;
         if (!wr_if.busy) break;
         if (n == wr_at) chk("wr_ready_during_fill", {31'd0, wr_if.wr_ready}, 32'd0);
         n++;
         rtick(1'b0);
         if (n == wr_at) begin
            wr_if.wr_en   = 1'b1;
            wr_if.wr_x    = 5'd0;
            wr_if.wr_y    = 4'd0;
            wr_if.wr_tile = 4'd9;
         end
      end
      chk(name, n, 300);
      model_fill();
      model_idle = 1'b1;
   endtask

   initial begin
      int v;
      rst = 1'b1;
      wr_if.wr_en = 1'b0; wr_if.clr = 1'b0;
      wr_if.wr_x = '0; wr_if.wr_y = '0; wr_if.wr_tile = '0;
      h_cnt = 10'd100; v_cnt = 10'd70; valid = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_pixel", {20'd0, pixel}, 32'd0);
      chk("reset_rom_addr", {18'd0, rom_addr}, 32'd0);
      chk("reset_hsync_out", {31'd0, hsync_out}, 32'd1);
      chk("reset_vsync_out", {31'd0, vsync_out}, 32'd1);
      chk("reset_busy", {31'd0, wr_if.busy}, 32'd1);
      chk("reset_wr_ready", {31'd0, wr_if.wr_ready}, 32'd0);
      rst = 1'b0;
      wait_fill("reset_fill_len", 100);
      chk("wr_ready_idle", {31'd0, wr_if.wr_ready}, 32'd1);

      // Filled map, and the write issued during the fill left cell (0,0) at 1.
      tick(639, 479, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick(100, 70, 1'b1, 1'b1, 1'b0, 1'b1);

      // Write then render.
      do_wr(3, 2, 7);
      tick(100, 70, 1'b1, 1'b1, 1'b0, 1'b1);
      repeat (4) rtick(1'b1);

      // Blanking with the ROM driving all ones.
      repeat (3) tick(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      rom_force = 1'b1;
      repeat (6) tick(700, $urandom_range(0, 524), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      repeat (3) tick(700, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      rom_force = 1'b0;

      // Out-of-range writes are dropped.
      do_wr(20, 0, 5);
      do_wr(0, 15, 6);
      do_wr(31, 14, 4);
      tick(0, 32, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(639, 0, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(0, 479, 1'b1, 1'b1, 1'b1, 1'b1);

      // clr together with wr_en in IDLE: refill starts, write dropped.
      tick(5 * 32, 5 * 32, 1'b1, 1'b1, 1'b1, 1'b1);
      #1;
      chk("busy_before_clr", {31'd0, wr_if.busy}, 32'd0);
      wr_if.clr = 1'b1;
      wr_if.wr_en = 1'b1; wr_if.wr_x = 5'd5; wr_if.wr_y = 4'd5; wr_if.wr_tile = 4'd3;
      model_idle = 1'b0;
      rtick(1'b0);
      wait_fill("clr_fill_len", -1);
      repeat (4) rtick(1'b1);

      // Random map, writes interleaved with checked reads.
      for (int i = 0; i < 350; i++)
         do_wr($urandom_range(0, 23), $urandom_range(0, 15), $urandom_range(0, 15));
      repeat (20) rtick(1'b1);

      // Sweep of scan lines across the frame, including blanking.
      for (int l = 0; l < 30; l++) begin
         v = l * 17 + $urandom_range(0, 16);
         for (int h = 0; h < 800; h++)
            tick(h, v, (h < 640 && v < 480), !(h >= 656 && h < 752), !(v >= 490 && v < 492), 1'b1);
      end
      repeat (20) tick($urandom_range(0, 1023), $urandom_range(512, 1023), 1'b1, 1'b1, 1'b1, 1'b1);

      // Reset in the middle of a refill restarts it from cell 0.
      tick(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      wr_if.clr = 1'b1;
      model_idle = 1'b0;
      repeat (150) rtick(1'b0);
      rtick(1'b0);
      rst = 1'b1;
      rtick(1'b0);
      rst = 1'b0;
      wait_fill("rst_midfill_len", -1);
      repeat (40) rtick(1'b1);

      repeat (5) tick(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("scoreboard_drained", aq.size() + pq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
